// File: rtl/ctrl_burst_cas_if.sv
// Shared DDR request encodings and the ACT-stage / CAS-stage handshake bundle.
// master = ACT stage (drives handshakes), slave = CAS scheduler.
package ddr_pkg;
  localparam logic [2:0] RD_R = 3'd1;
  localparam logic [2:0] WR_R = 3'd2;
endpackage

interface ctrl_burst_cas_if;
  logic        act_rdy;
  logic        no_act_rdy;
  logic [2:0]  act_rw;
  logic [1:0]  bg_addr;
  logic [1:0]  ba_addr;
  logic [9:0]  col_addr;
  logic        cas_rdy;
  logic        cas_rd;
  logic        cas_wr;
  logic [2:0]  cas_req;
  logic [13:0] cas_addr;
  logic        cas_idle;
  logic        proto_err;

  modport master (
    output act_rdy, no_act_rdy, act_rw, bg_addr, ba_addr, col_addr,
    input  cas_rdy, cas_rd, cas_wr, cas_req, cas_addr, cas_idle, proto_err
  );
  modport slave (
    input  act_rdy, no_act_rdy, act_rw, bg_addr, ba_addr, col_addr,
    output cas_rdy, cas_rd, cas_wr, cas_req, cas_addr, cas_idle, proto_err
  );
endinterface

// File: rtl/ctrl_burst_cas.sv
// CAS scheduler: waits tRCD after ACTIVATE, enforces CAS-to-CAS spacing, strobes READ/WRITE.
// Optional write-to-read gap enforcement: define CAS_WTR_CHECK_EN.
module ctrl_burst_cas
  import ddr_pkg::*;
#(
  parameter int unsigned T_RCD     = 16,
  parameter int unsigned T_CCD     = 4,
  parameter int unsigned T_WTR_GAP = 12
) (
  input  logic             CK_t,
  input  logic             reset_n,
  ctrl_burst_cas_if.slave  bus
);

  typedef enum logic [1:0] {CAS_IDLE, CAS_WAIT_RCD, CAS_WAIT_GAP, CAS_ISSUE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  rcd_q, rcd_d;
  logic [7:0]  gap_q, gap_d;
  logic [2:0]  req_rw_q, req_rw_d;
  logic [13:0] req_addr_q, req_addr_d;
  logic        cas_rdy_q, cas_rdy_d;
  logic        cas_rd_q, cas_rd_d;
  logic        cas_wr_q, cas_wr_d;
  logic [2:0]  cas_req_q, cas_req_d;
  logic [13:0] cas_addr_q, cas_addr_d;
  logic        cas_idle_q, cas_idle_d;
  logic        proto_err_q, proto_err_d;

  logic        hs, rw_legal, spacing_ok;
  logic [8:0]  gap_nxt;

  assign hs       = bus.act_rdy | bus.no_act_rdy;
  assign rw_legal = (bus.act_rw == RD_R) || (bus.act_rw == WR_R);
  // gap_q reads 0 in the strobe cycle, so gap_q+1 is the distance a strobe next cycle would have
  assign gap_nxt  = {1'b0, gap_q} + 9'd1;

`ifdef CAS_WTR_CHECK_EN
  logic last_wr_q, last_wr_d;
  logic wtr_ok;
  assign wtr_ok     = !(last_wr_q && (req_rw_q == RD_R)) || (gap_nxt >= 9'(T_WTR_GAP));
  assign spacing_ok = (gap_nxt >= 9'(T_CCD)) && wtr_ok;

  always_comb begin
    last_wr_d = last_wr_q;
    if (state_d == CAS_ISSUE) last_wr_d = (req_rw_q == WR_R);
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) last_wr_q <= 1'b0;
    else          last_wr_q <= last_wr_d;
  end
`else
  assign spacing_ok = (gap_nxt >= 9'(T_CCD));
`endif

  always_comb begin
    state_d     = state_q;
    rcd_d       = (rcd_q != 8'd0) ? rcd_q - 8'd1 : 8'd0;
    gap_d       = (gap_q == 8'hFF) ? gap_q : gap_q + 8'd1;
    req_rw_d    = req_rw_q;
    req_addr_d  = req_addr_q;
    proto_err_d = 1'b0;
    case (state_q)
      CAS_IDLE: begin
        if (hs) begin
          if (!rw_legal) begin
            proto_err_d = 1'b1;
          end else begin
            req_rw_d    = bus.act_rw;
            req_addr_d  = {bus.bg_addr, bus.ba_addr, bus.col_addr};
            proto_err_d = bus.act_rdy & bus.no_act_rdy;
            if (bus.act_rdy) begin
              rcd_d   = 8'(T_RCD - 1);
              state_d = CAS_WAIT_RCD;
            end else begin
              state_d = CAS_WAIT_GAP;
            end
          end
        end
      end
      CAS_WAIT_RCD: begin
        proto_err_d = hs;
        if (rcd_q <= 8'd1) state_d = spacing_ok ? CAS_ISSUE : CAS_WAIT_GAP;
      end
      CAS_WAIT_GAP: begin
        proto_err_d = hs;
        if (spacing_ok) state_d = CAS_ISSUE;
      end
      default: begin
        proto_err_d = hs;
        state_d     = CAS_IDLE;
      end
    endcase

    cas_rdy_d  = (state_d == CAS_ISSUE);
    cas_rd_d   = cas_rdy_d && (req_rw_q == RD_R);
    cas_wr_d   = cas_rdy_d && (req_rw_q == WR_R);
    cas_req_d  = cas_req_q;
    cas_addr_d = cas_addr_q;
    cas_idle_d = (state_d == CAS_IDLE);
    if (cas_rdy_d) begin
      cas_req_d  = req_rw_q;
      cas_addr_d = req_addr_q;
      gap_d      = 8'd0;
    end
  end

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CAS_IDLE;
      rcd_q       <= 8'd0;
      gap_q       <= 8'hFF;
      req_rw_q    <= 3'd0;
      req_addr_q  <= 14'd0;
      cas_rdy_q   <= 1'b0;
      cas_rd_q    <= 1'b0;
      cas_wr_q    <= 1'b0;
      cas_req_q   <= 3'd0;
      cas_addr_q  <= 14'd0;
      cas_idle_q  <= 1'b1;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rcd_q       <= rcd_d;
      gap_q       <= gap_d;
      req_rw_q    <= req_rw_d;
      req_addr_q  <= req_addr_d;
      cas_rdy_q   <= cas_rdy_d;
      cas_rd_q    <= cas_rd_d;
      cas_wr_q    <= cas_wr_d;
      cas_req_q   <= cas_req_d;
      cas_addr_q  <= cas_addr_d;
      cas_idle_q  <= cas_idle_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign bus.cas_rdy   = cas_rdy_q;
  assign bus.cas_rd    = cas_rd_q;
  assign bus.cas_wr    = cas_wr_q;
  assign bus.cas_req   = cas_req_q;
  assign bus.cas_addr  = cas_addr_q;
  assign bus.cas_idle  = cas_idle_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_ctrl_burst_cas.sv
// Scoreboard bench for ctrl_burst_cas: stimulus queues expected strobes/protocol errors,
// a negedge monitor pops and compares. Cycle k is the clock period ending at rising edge k.
module tb_ctrl_burst_cas;
  import ddr_pkg::*;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [13:0] addr;
  } exp_cas_t;

  logic CK_t = 1'b0;
  logic reset_n;
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  exp_cas_t exp_q[$];
  int       perr_q[$];

  ctrl_burst_cas_if bus();

  ctrl_burst_cas #(.T_RCD(16), .T_CCD(4), .T_WTR_GAP(12)) dut (
    .CK_t    (CK_t),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 CK_t = ~CK_t;
  always @(posedge CK_t) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, edge_cnt + 1);
    end
  endtask

  // Monitor: every strobe / protocol-error pulse must match the head of its queue
  always @(negedge CK_t) begin
    if (bus.cas_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_cas_rdy", 1, 0);
      end else begin
        exp_cas_t e;
        e = exp_q.pop_front();
        chk("cas_cycle", edge_cnt + 1, e.cyc);
        chk("cas_rd_wr", {bus.cas_rd, bus.cas_wr}, e.wr ? 2'b01 : 2'b10);
        chk("cas_addr", bus.cas_addr, e.addr);
        chk("cas_req", bus.cas_req, e.wr ? WR_R : RD_R);
      end
    end
    if (bus.proto_err === 1'b1) begin
      if (perr_q.size() == 0) chk("unexpected_proto_err", 1, 0);
      else                    chk("proto_err_cycle", edge_cnt + 1, perr_q.pop_front());
    end
  end

  task automatic wait_cycle(input int k);
    while (edge_cnt < k - 1) begin
      @(posedge CK_t);
      #2;
    end
  endtask

  // Drive a handshake during cycle n (sampled at edge n); returns 2 time units into cycle n+1
  task automatic hs(input int n, input bit a, input bit h, input logic [2:0] rw,
                    input logic [1:0] bg, input logic [1:0] ba, input logic [9:0] col);
    wait_cycle(n);
    bus.act_rdy    = a;
    bus.no_act_rdy = h;
    bus.act_rw     = rw;
    bus.bg_addr    = bg;
    bus.ba_addr    = ba;
    bus.col_addr   = col;
    @(posedge CK_t);
    #2;
    bus.act_rdy    = 1'b0;
    bus.no_act_rdy = 1'b0;
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.act_rdy    = 1'b0;
    bus.no_act_rdy = 1'b0;
    bus.act_rw     = 3'd0;
    bus.bg_addr    = 2'd0;
    bus.ba_addr    = 2'd0;
    bus.col_addr   = 10'd0;
    wait_cycle(3);
    reset_n = 1'b1;

    wait_cycle(4);
    chk("rst_cas_idle", bus.cas_idle, 1);
    chk("rst_cas_addr", bus.cas_addr, 14'h0000);
    chk("rst_cas_req", bus.cas_req, 3'd0);

    // Row hit, READ: strobe in cycle 12
    exp_q.push_back('{12, 1'b0, 14'h183F});
    wait_cycle(10);
    chk("idle_before_hs", bus.cas_idle, 1);
    hs(10, 1'b0, 1'b1, RD_R, 2'd1, 2'd2, 10'h03F);
    chk("idle_c11", bus.cas_idle, 0);
    wait_cycle(12);
    chk("idle_c12", bus.cas_idle, 0);
    wait_cycle(13);
    chk("idle_c13", bus.cas_idle, 1);
    chk("addr_hold_c13", bus.cas_addr, 14'h183F);

    // Back-to-back hit: T_CCD pushes the strobe from 15 to 16
    exp_q.push_back('{16, 1'b0, 14'h0010});
    hs(13, 1'b0, 1'b1, RD_R, 2'd0, 2'd0, 10'h010);

    // ACTIVATE, WRITE: strobe at 20 + T_RCD
    exp_q.push_back('{36, 1'b1, 14'h3555});
    hs(20, 1'b1, 1'b0, WR_R, 2'd3, 2'd1, 10'h155);

    // WRITE at 50, then READ hit at 51
    exp_q.push_back('{50, 1'b1, 14'h0FFF});
    hs(48, 1'b0, 1'b1, WR_R, 2'd0, 2'd3, 10'h3FF);
`ifdef CAS_WTR_CHECK_EN
    exp_q.push_back('{62, 1'b0, 14'h2001});
`else
    exp_q.push_back('{54, 1'b0, 14'h2001});
`endif
    hs(51, 1'b0, 1'b1, RD_R, 2'd2, 2'd0, 10'h001);

    // Both handshakes together: treated as ACTIVATE, proto_err
    exp_q.push_back('{86, 1'b1, 14'h1C22});
    perr_q.push_back(71);
    hs(70, 1'b1, 1'b1, WR_R, 2'd1, 2'd3, 10'h022);
    // Handshake while waiting tRCD: dropped, strobe unchanged
    perr_q.push_back(76);
    hs(75, 1'b0, 1'b1, RD_R, 2'd3, 2'd3, 10'h3AA);
    // Illegal request type: dropped, no strobe
    perr_q.push_back(91);
    hs(90, 1'b0, 1'b1, 3'd0, 2'd2, 2'd2, 10'h111);
    wait_cycle(93);
    chk("idle_after_bad_rw", bus.cas_idle, 1);

    // Reset while waiting tRCD: no strobe afterwards
    hs(100, 1'b1, 1'b0, RD_R, 2'd1, 2'd1, 10'h0AA);
    wait_cycle(105);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_cas_idle", bus.cas_idle, 1);
    chk("midrst_cas_addr", bus.cas_addr, 14'h0000);
    chk("midrst_cas_req", bus.cas_req, 3'd0);
    chk("midrst_cas_rdy", bus.cas_rdy, 0);
    wait_cycle(108);
    reset_n = 1'b1;

    // First CAS after reset is not delayed by spacing
    exp_q.push_back('{122, 1'b0, 14'h0405});
    hs(120, 1'b0, 1'b1, RD_R, 2'd0, 2'd1, 10'h005);

    wait_cycle(140);
    chk("cas_queue_drained", exp_q.size(), 0);
    chk("perr_queue_drained", perr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
